alu_mc: RTL

//  Multi-cycle, parametrised ALU with valid/ready handshakes on operand and result sides.

---
 rtl/alu_mc.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_mc.sv
// rtl/alu_mc.sv - multi-cycle ALU with operand/result valid-ready handshakes
// Build option ALU_DIV_EN adds the iterative DIVU/REMU divider; otherwise those opcodes act as reserved.
module alu_mc #(
  parameter int DATA_WIDTH = 32,
  parameter int ITER_BITS  = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  input  logic [3:0]            ALUop,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] Result,
  output logic                  Overflow,
  output logic                  CarryOut,
  output logic                  Zero,
  output logic                  busy
);
  localparam int W         = DATA_WIDTH;
  localparam int SW        = $clog2(DATA_WIDTH);
  localparam int MUL_STEPS = DATA_WIDTH / ITER_BITS;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SLTU  = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_NOR   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_SLL   = 4'b1000;
  localparam logic [3:0] OP_SRL   = 4'b1001;
  localparam logic [3:0] OP_SRA   = 4'b1010;
  localparam logic [3:0] OP_MUL   = 4'b1011;
  localparam logic [3:0] OP_MULHU = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [3:0]      op_q;
  logic [W-1:0]    a_q;
  logic [2*W-1:0]  prod;
  logic [SW-1:0]   cnt;

  logic            accept;
  logic            is_mul;
  logic            is_div;
  logic            hi_sel;
  logic [SW-1:0]   last_cnt;
  logic [2*W-1:0]  step_next;
  logic [W-1:0]    res_sel;

  assign in_ready = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept   = in_valid && in_ready;
  assign is_mul   = (ALUop == OP_MUL) || (ALUop == OP_MULHU);

  // Single-cycle datapath works straight off the inputs so the result lands on the accept edge.
  logic          is_sub;
  logic [W-1:0]  b_eff;
  logic [W:0]    sum;
  logic          add_ovf;
  logic          add_cout;
  logic [SW-1:0] shamt;
  logic [W-1:0]  sc_result;
  logic          sc_ovf;
  logic          sc_cout;

  always_comb begin
    is_sub    = (ALUop == OP_SUB) || (ALUop == OP_SLT) || (ALUop == OP_SLTU);
    b_eff     = is_sub ? ~B : B;
    sum       = {1'b0, A} + {1'b0, b_eff} + {{W{1'b0}}, is_sub};
    add_cout  = sum[W] ^ is_sub;
    add_ovf   = (A[W-1] == b_eff[W-1]) && (sum[W-1] != A[W-1]);
    shamt     = B[SW-1:0];
    sc_result = '0;
    sc_ovf    = 1'b0;
    sc_cout   = 1'b0;
    case (ALUop)
      OP_AND:  sc_result = A & B;
      OP_OR:   sc_result = A | B;
      OP_ADD,
      OP_SUB: begin
        sc_result = sum[W-1:0];
        sc_ovf    = add_ovf;
        sc_cout   = add_cout;
      end
      OP_SLTU: sc_result = {{(W-1){1'b0}}, add_cout};
      OP_XOR:  sc_result = A ^ B;
      OP_NOR:  sc_result = ~(A | B);
      OP_SLT:  sc_result = {{(W-1){1'b0}}, sum[W-1] ^ add_ovf};
      OP_SLL:  sc_result = A << shamt;
      OP_SRL:  sc_result = A >> shamt;
      OP_SRA:  sc_result = $signed(A) >>> shamt;
      default: sc_result = '0;
    endcase
  end

  // Shift-add multiplier: prod = {accumulator, remaining multiplier bits}, ITER_BITS digits per step.
  logic [W+ITER_BITS-1:0] partial;
  logic [W+ITER_BITS-1:0] hi_sum;
  logic [2*W-1:0]         mul_next;

  always_comb begin
    partial = '0;
    for (int j = 0; j < ITER_BITS; j++) begin
      if (prod[j]) partial = partial + ({{ITER_BITS{1'b0}}, a_q} << j);
    end
    hi_sum   = {{ITER_BITS{1'b0}}, prod[2*W-1:W]} + partial;
    mul_next = {hi_sum, prod[W-1:ITER_BITS]};
  end

`ifdef ALU_DIV_EN
  localparam logic [3:0] OP_DIVU = 4'b1101;
  localparam logic [3:0] OP_REMU = 4'b1110;

  // Restoring divider: prod = {remainder, dividend/quotient}; a zero divisor naturally yields
  // an all-ones quotient and a remainder equal to the dividend.
  logic [W-1:0]   b_q;
  logic [W+1:0]   div_diff;
  logic [2*W-1:0] div_next;
  logic           op_div_q;

  always_comb begin
    div_diff = {1'b0, prod[2*W-1:W-1]} - {2'b00, b_q};
    if (div_diff[W+1]) div_next = {prod[2*W-2:0], 1'b0};
    else               div_next = {div_diff[W-1:0], prod[W-2:0], 1'b1};
  end

  assign is_div    = (ALUop == OP_DIVU) || (ALUop == OP_REMU);
  assign op_div_q  = (op_q == OP_DIVU) || (op_q == OP_REMU);
  assign step_next = op_div_q ? div_next : mul_next;
  assign hi_sel    = (op_q == OP_MULHU) || (op_q == OP_REMU);
`else
  assign is_div    = 1'b0;
  assign step_next = mul_next;
  assign hi_sel    = (op_q == OP_MULHU);
`endif

  assign last_cnt = ((op_q == OP_MUL) || (op_q == OP_MULHU)) ? SW'(MUL_STEPS - 1) : SW'(W - 1);
  assign res_sel  = hi_sel ? step_next[2*W-1:W] : step_next[W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      op_q      <= '0;
      a_q       <= '0;
      prod      <= '0;
      cnt       <= '0;
      Result    <= '0;
      Overflow  <= 1'b0;
      CarryOut  <= 1'b0;
      Zero      <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef ALU_DIV_EN
      b_q       <= '0;
`endif
    end else begin
      case (state)
        IDLE,
        DONE: begin
          if (accept) begin
            op_q <= ALUop;
            a_q  <= A;
            cnt  <= '0;
            prod <= is_div ? {{W{1'b0}}, A} : {{W{1'b0}}, B};
`ifdef ALU_DIV_EN
            b_q  <= B;
`endif
            if (is_mul || is_div) begin
              state     <= BUSY;
              busy      <= 1'b1;
              out_valid <= 1'b0;
            end else begin
              state     <= DONE;
              out_valid <= 1'b1;
              Result    <= sc_result;
              Overflow  <= sc_ovf;
              CarryOut  <= sc_cout;
              Zero      <= (sc_result == '0);
            end
          end else if ((state == DONE) && out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        BUSY: begin
          prod <= step_next;
          cnt  <= cnt + 1'b1;
          // The final step's value is taken combinationally so DONE follows the last BUSY cycle.
          if (cnt == last_cnt) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            Result    <= res_sel;
            Overflow  <= 1'b0;
            CarryOut  <= 1'b0;
            Zero      <= (res_sel == '0);
          end
        end
        default: begin
          state     <= IDLE;
          busy      <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule
